// File: rtl/normalize_float64.sv
// Normalisation stage ahead of float64 round-and-pack: multi-cycle leading-zero
// search, then shifts the significand so bit 62 holds the leading one.
module normalize_float64 (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic        zSign,
    input  logic [11:0] zExp,
    input  logic [63:0] zSig,
    output logic        zSign_o,
    output logic [11:0] zExp_o,
    output logic [63:0] zSig_o,
    output logic [6:0]  shiftCount_o
);

    localparam logic [4:0] S1 = 5'b00001;
    localparam logic [4:0] S2 = 5'b00010;
    localparam logic [4:0] S3 = 5'b00100;
    localparam logic [4:0] S4 = 5'b01000;
    localparam logic [4:0] S5 = 5'b10000;

    logic [4:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [11:0] exp_q, exp_d;
    logic [63:0] work_q, work_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        out_sign_q, out_sign_d;
    logic [11:0] out_exp_q, out_exp_d;
    logic [63:0] out_sig_q, out_sig_d;
    logic [6:0]  out_sc_q, out_sc_d;

    function automatic logic [3:0] clz8(input logic [7:0] b);
        casez (b)
            8'b1???????: clz8 = 4'd0;
            8'b01??????: clz8 = 4'd1;
            8'b001?????: clz8 = 4'd2;
            8'b0001????: clz8 = 4'd3;
            8'b00001???: clz8 = 4'd4;
            8'b000001??: clz8 = 4'd5;
            8'b0000001?: clz8 = 4'd6;
            8'b00000001: clz8 = 4'd7;
            default:     clz8 = 4'd8;
        endcase
    endfunction

    // Final step: after the optional 8-bit shift the leading one (if any) sits
    // in the top byte, so only a short shift remains to place it at bit 62.
    logic        top_zero;
    logic [63:0] w8;
    logic [6:0]  c8;
    logic [3:0]  lz8;
    logic [6:0]  shift_count;
    logic [63:0] norm_sig;

    always_comb begin
        top_zero    = (work_q[63:56] == 8'h00);
        w8          = top_zero ? (work_q << 8) : work_q;
        c8          = cnt_q + (top_zero ? 7'd8 : 7'd0);
        lz8         = clz8(w8[63:56]);
        shift_count = c8 + {3'b000, lz8} - 7'd1;
        if (lz8 == 4'd0) begin
            // Leading one at bit 63: shift right one place, jamming the lost bit.
            norm_sig = {1'b0, w8[63:1]} | {63'd0, w8[0]};
        end else begin
            norm_sig = w8 << (lz8 - 4'd1);
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        out_sign_d = out_sign_q;
        out_exp_d  = out_exp_q;
        out_sig_d  = out_sig_q;
        out_sc_d   = out_sc_q;
        case (state_q)
            S1: begin
                if (ap_start) begin
                    sign_d  = zSign;
                    exp_d   = zExp;
                    work_d  = zSig;
                    cnt_d   = 7'd0;
                    state_d = S2;
                end
            end
            S2: begin
                if (work_q[63:32] == 32'd0) begin
                    cnt_d  = 7'd32;
                    work_d = work_q << 32;
                end else begin
                    cnt_d = 7'd0;
                end
                state_d = S3;
            end
            S3: begin
                if (work_q[63:48] == 16'd0) begin
                    cnt_d  = cnt_q + 7'd16;
                    work_d = work_q << 16;
                end
                state_d = S4;
            end
            S4: begin
                work_d     = w8;
                cnt_d      = c8;
                out_sign_d = sign_q;
                out_exp_d  = exp_q - {{5{shift_count[6]}}, shift_count};
                out_sig_d  = norm_sig;
                out_sc_d   = shift_count;
                state_d    = S5;
            end
            S5:      state_d = S1;
            default: state_d = S1;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        // NOTE: non-blocking assignments throughout; reset is synchronous and
        // clears every register, including the held outputs.
        if (ap_rst) begin
            state_q    <= S1;
            sign_q     <= 1'b0;
            exp_q      <= 12'd0;
            work_q     <= 64'd0;
            cnt_q      <= 7'd0;
            out_sign_q <= 1'b0;
            out_exp_q  <= 12'd0;
            out_sig_q  <= 64'd0;
            out_sc_q   <= 7'd0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            out_sign_q <= out_sign_d;
            out_exp_q  <= out_exp_d;
            out_sig_q  <= out_sig_d;
            out_sc_q   <= out_sc_d;
        end
    end

    assign ap_idle      = state_q[0] & ~ap_start;
    assign ap_done      = state_q[4];
    assign ap_ready     = state_q[4];
    assign zSign_o      = out_sign_q;
    assign zExp_o       = out_exp_q;
    assign zSig_o       = out_sig_q;
    assign shiftCount_o = out_sc_q;

endmodule

// File: tb/tb_normalize_float64.sv
// Randomised bench for normalize_float64 against a bit-scan reference model
// with cycle-exact done/idle timing and held-output checking.
module tb_normalize_float64;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic        zSign;
    logic [11:0] zExp;
    logic [63:0] zSig;
    logic        zSign_o;
    logic [11:0] zExp_o;
    logic [63:0] zSig_o;
    logic [6:0]  shiftCount_o;

    normalize_float64 dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .zSign(zSign), .zExp(zExp), .zSig(zSig),
        .zSign_o(zSign_o), .zExp_o(zExp_o), .zSig_o(zSig_o),
        .shiftCount_o(shiftCount_o)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        logic        s;
        logic [11:0] e;
        logic [63:0] z;
        logic [6:0]  sc;
        int          done_cyc;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_free = 0;
    bit   armed = 0;
    res_t pend[$];
    res_t held;
    int   done_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: find the leading one by scanning, then apply the shift rules.
    function automatic res_t model(input logic s, input logic [11:0] e, input logic [63:0] z);
        res_t r;
        int clz = 64;
        int sc;
        for (int i = 63; i >= 0; i--) begin
            if (z[i]) begin
                clz = 63 - i;
                break;
            end
        end
        sc = clz - 1;
        r.s  = s;
        r.sc = 7'(sc);
        r.done_cyc = 0;
        if (sc < 0) begin
            r.z = (z >> 1) | (z & 64'd1);
            r.e = e + 12'd1;
        end else begin
            r.z = z << sc;
            r.e = e - 12'(sc);
        end
        return r;
    endfunction

    // Timing model: an accepted start produces done three edges later and the
    // block can accept again five edges after the accepting edge.
    always @(posedge ap_clk) begin
        cyc++;
        if (ap_rst) begin
            pend.delete();
            next_free = cyc + 1;
            held = '{1'b0, 12'd0, 64'd0, 7'd0, 0};
            armed = 1;
        end else if (armed && ap_start && next_free <= cyc) begin
            res_t r;
            r = model(zSign, zExp, zSig);
            r.done_cyc = cyc + 3;
            pend.push_back(r);
            next_free = cyc + 5;
        end
    end

    always @(negedge ap_clk) begin
        if (armed) begin
            logic exp_done;
            exp_done = (pend.size() > 0) && (pend[0].done_cyc == cyc);
            if (exp_done) begin
                held = pend.pop_front();
                done_log.push_back(cyc);
            end
            check("ap_done", 64'(ap_done), 64'(exp_done));
            check("ap_ready", 64'(ap_ready), 64'(exp_done));
            check("ap_idle", 64'(ap_idle), 64'((next_free <= cyc + 1) && !ap_start));
            check("zSign_o", 64'(zSign_o), 64'(held.s));
            check("zExp_o", 64'(zExp_o), 64'(held.e));
            check("zSig_o", zSig_o, held.z);
            check("shiftCount_o", 64'(shiftCount_o), 64'(held.sc));
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_free();
        int guard = 0;
        while (next_free > cyc + 1) begin
            tick();
            guard++;
            if (guard > 20) begin
                check("wait_free_timeout", 64'(guard), 64'd0);
                break;
            end
        end
    endtask

    task automatic start_op(input logic s, input logic [11:0] e, input logic [63:0] z);
        wait_free();
        zSign = s;
        zExp = e;
        zSig = z;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        zSign = ~s;
        zExp = 12'($urandom);
        zSig = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] rand_sig();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) r[63] = 1'b1;
        return r >> $urandom_range(0, 64);
    endfunction

    task automatic pin(input string name, input logic [63:0] z, input logic [11:0] e,
                       input logic [6:0] sc, input logic [63:0] zo, input logic [11:0] eo);
        res_t r;
        r = model(1'b1, e, z);
        check({name, "_sc"}, 64'(r.sc), 64'(sc));
        check({name, "_z"}, r.z, zo);
        check({name, "_e"}, 64'(r.e), 64'(eo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, lc;
        ap_rst = 1'b1;
        ap_start = 1'b0;
        zSign = 1'b0;
        zExp = 12'd0;
        zSig = 64'd0;

        pin("pin_one", 64'h1, 12'h43E, 7'd62, 64'h4000_0000_0000_0000, 12'h400);
        pin("pin_top", 64'h8000_0000_0000_0003, 12'h100, 7'h7F, 64'h4000_0000_0000_0001, 12'h101);
        pin("pin_zero", 64'h0, 12'h010, 7'd63, 64'h0, 12'hFD1);
        pin("pin_norm", 64'h4000_0000_0000_0000, 12'h3FF, 7'd0, 64'h4000_0000_0000_0000, 12'h3FF);
        pin("pin_b32", 64'h0000_0001_0000_0000, 12'h000, 7'd30, 64'h4000_0000_0000_0000, 12'hFE2);

        tick(); tick();
        ap_rst = 1'b0;
        repeat (3) tick();

        start_op(1'b1, 12'h43E, 64'h1);
        start_op(1'b0, 12'h100, 64'h8000_0000_0000_0003);
        start_op(1'b0, 12'h010, 64'h0);
        start_op(1'b1, 12'h3FF, 64'h4000_0000_0000_0000);
        start_op(1'b0, 12'h000, 64'h0000_0001_0000_0000);

        // Back-to-back with ap_start held: second operand presented after accept.
        wait_free();
        lc = done_log.size();
        zSign = 1'b0; zExp = 12'h123; zSig = 64'h0000_0000_00F0_0000;
        ap_start = 1'b1;
        tick();
        zSign = 1'b1; zExp = 12'h7FF; zSig = 64'h0000_8000_0000_0000;
        repeat (5) tick();
        ap_start = 1'b0;
        repeat (6) tick();
        if (done_log.size() >= lc + 2) begin
            d0 = done_log[lc];
            d1 = done_log[lc + 1];
            check("b2b_spacing", 64'(d1 - d0), 64'd5);
        end else begin
            check("b2b_done_count", 64'(done_log.size() - lc), 64'd2);
        end

        // Reset while the operation sits in S3.
        wait_free();
        start_op(1'b1, 12'h555, 64'h0000_0000_0000_00FF);
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_op(1'($urandom), 12'($urandom), rand_sig());
        end

        lc = 0;
        while (pend.size() > 0 && lc < 20) begin
            tick();
            lc++;
        end
        check("drain", 64'(pend.size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
